// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store data memory.
//   - access size encodings used on the size port
//   - FSM state type and state constants
//   - upper bound for the wait-state count
//   - alignment helper shared by anything that decodes an access
`timescale 1ns/1ps
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MAX_LATENCY = 15;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Size 11 is never a legal access, so it is reported like a misaligned one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = low[0];
      SZ_WORD: bad = (low != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/be_ram.sv
// be_ram: word-organised storage with per-byte write enables.
// Ports:
//   clk    - write clock
//   be     - byte enables, bit i writes lane i (bits [8i+7:8i])
//   index  - word index (byte address without its two low bits)
//   wdata  - write data, already steered onto the enabled lanes
//   rdata  - combinational read of the addressed word
// Contents are not reset.
`timescale 1ns/1ps
module be_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-3:0] index,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  logic [31:0] mem [DEPTH];

  // Each lane is written independently so sub-word stores leave the
  // neighbouring bytes alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/data_mem_ls.sv
// data_mem_ls: multi-cycle data memory with MIPS load/store semantics.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   req          - request valid, accepted only while ready is high
//   we           - 1 = store, 0 = load
//   size         - 00 byte, 01 half, 10 word, 11 illegal
//   unsigned_ld  - zero-extend (1) or sign-extend (0) sub-word loads
//   addr         - little-endian byte address
//   wdata        - right-aligned store data
//   ready        - high only in IDLE
//   rvalid       - one-cycle response strobe (RESP state)
//   rdata        - extended load result, 0 for stores and errors
//   misaligned   - error flag, qualified by rvalid
// Aligned accesses commit LATENCY edges after acceptance; misaligned
// ones respond on the next cycle without touching storage.
`timescale 1ns/1ps
module data_mem_ls
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [31:0]           rdata,
  output logic                  misaligned
);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("data_mem_ls: DATA_WIDTH must be 32");
    end
    if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("data_mem_ls: LATENCY out of range 0..15");
    end
  endgenerate

  localparam logic       ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t                state;
  logic [3:0]            cnt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic                  in_mis;
  logic                  commit;
  logic                  op_we;
  logic [1:0]            op_size;
  logic                  op_uns;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [31:0]           op_wdata;
  logic [3:0]            be;
  logic [31:0]           lane_wdata;
  logic [31:0]           ram_rdata;
  logic [31:0]           load_val;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  assign ready  = (state == ST_IDLE);
  assign rvalid = (state == ST_RESP);
  assign in_mis = is_misaligned(size, addr[1:0]);

  // With zero wait states the commit happens on the acceptance edge itself,
  // so the live inputs drive the storage while IDLE; otherwise the captured
  // copy does.
  assign op_we    = (state == ST_IDLE) ? we          : r_we;
  assign op_size  = (state == ST_IDLE) ? size        : r_size;
  assign op_uns   = (state == ST_IDLE) ? unsigned_ld : r_uns;
  assign op_addr  = (state == ST_IDLE) ? addr        : r_addr;
  assign op_wdata = (state == ST_IDLE) ? wdata       : r_wdata;

  assign commit = ((state == ST_IDLE) && req && !in_mis && ZERO_LAT) ||
                  ((state == ST_WAIT) && (cnt == 4'd0));

  // Byte enables and lane replication for stores.
  always_comb begin
    be         = 4'b0000;
    lane_wdata = op_wdata;
    case (op_size)
      SZ_BYTE: begin
        be         = 4'b0001 << op_addr[1:0];
        lane_wdata = {4{op_wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = op_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{op_wdata[15:0]}};
      end
      SZ_WORD: begin
        be         = 4'b1111;
        lane_wdata = op_wdata;
      end
      default: begin
        be         = 4'b0000;
        lane_wdata = op_wdata;
      end
    endcase
    if (!(commit && op_we)) begin
      be = 4'b0000;
    end
  end

  be_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .be    (be),
    .index (op_addr[ADDR_WIDTH-1:2]),
    .wdata (lane_wdata),
    .rdata (ram_rdata)
  );

  // Lane selection and sign/zero extension of the loaded word.
  always_comb begin
    load_val = 32'd0;
    byte_v   = ram_rdata[{op_addr[1:0], 3'b000} +: 8];
    half_v   = op_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (op_size)
      SZ_BYTE: load_val = op_uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: load_val = op_uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      SZ_WORD: load_val = ram_rdata;
      default: load_val = 32'd0;
    endcase
  end

  // Control FSM. rdata/misaligned only change when a response is formed,
  // so they hold their last values outside RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      rdata      <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_uns   <= unsigned_ld;
            r_addr  <= addr;
            r_wdata <= wdata;
            if (in_mis) begin
              state      <= ST_RESP;
              rdata      <= 32'd0;
              misaligned <= 1'b1;
            end else if (ZERO_LAT) begin
              state      <= ST_RESP;
              rdata      <= we ? 32'd0 : load_val;
              misaligned <= 1'b0;
            end else begin
              state <= ST_WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= ST_RESP;
            rdata      <= r_we ? 32'd0 : load_val;
            misaligned <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ls.sv
// tb_data_mem_ls: self-checking bench for data_mem_ls.
// Three instances (LATENCY 2, 0 and 3) share the data inputs and clock;
// each has its own req and reset. A byte-array reference model tracks the
// expected storage contents per instance.
`timescale 1ns/1ps
module tb_data_mem_ls;

  logic        clk;
  logic        rst_n_v  [3];
  logic        req_v    [3];
  logic        we_s;
  logic [1:0]  size_s;
  logic        uns_s;
  logic [11:0] addr_s;
  logic [31:0] wdata_s;
  logic        ready_v  [3];
  logic        rvalid_v [3];
  logic [31:0] rdata_v  [3];
  logic        mis_v    [3];

  int          lat_of [3];
  logic [7:0]  mb [3][4096];

  int          total;
  int          bad;
  logic [31:0] got_rdata;
  logic        got_mis;
  int          got_lat;
  int          got_rlow;

  data_mem_ls #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .req(req_v[0]), .we(we_s), .size(size_s),
    .unsigned_ld(uns_s), .addr(addr_s), .wdata(wdata_s), .ready(ready_v[0]),
    .rvalid(rvalid_v[0]), .rdata(rdata_v[0]), .misaligned(mis_v[0]));

  data_mem_ls #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .LATENCY(0)) dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .req(req_v[1]), .we(we_s), .size(size_s),
    .unsigned_ld(uns_s), .addr(addr_s), .wdata(wdata_s), .ready(ready_v[1]),
    .rvalid(rvalid_v[1]), .rdata(rdata_v[1]), .misaligned(mis_v[1]));

  data_mem_ls #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .LATENCY(3)) dut2 (
    .clk(clk), .rst_n(rst_n_v[2]), .req(req_v[2]), .we(we_s), .size(size_s),
    .unsigned_ld(uns_s), .addr(addr_s), .wdata(wdata_s), .ready(ready_v[2]),
    .rvalid(rvalid_v[2]), .rdata(rdata_v[2]), .misaligned(mis_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: an access of 2**sz bytes is legal only when the
  // address is a multiple of its size; loads assemble bytes and extend.
  task automatic modelAccess(input int sel, input logic w, input logic [1:0] sz,
                             input logic u, input logic [11:0] a, input logic [31:0] wd,
                             output logic [31:0] er, output logic em);
    int     nbytes;
    longint v;
    nbytes = 1 << sz;
    em     = (sz == 2'b11) || ((int'(a) % nbytes) != 0);
    er     = 32'd0;
    if (!em) begin
      if (w) begin
        for (int i = 0; i < nbytes; i++) mb[sel][int'(a) + i] = wd[i*8 +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < nbytes; i++) v = v + (longint'(mb[sel][int'(a) + i]) << (8 * i));
        if (!u && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1))) begin
          v = v - (longint'(1) << (8 * nbytes));
        end
        er = v[31:0];
      end
    end
  endtask

  // Issue one access on instance sel and wait (bounded) for its response.
  task automatic applyStimulus(input int sel, input logic w, input logic [1:0] sz,
                               input logic u, input logic [11:0] a, input logic [31:0] wd);
    int   n;
    logic seen;
    @(negedge clk);
    checkOutput("ready_idle", 32'(ready_v[sel]), 32'd1);
    we_s = w; size_s = sz; uns_s = u; addr_s = a; wdata_s = wd;
    req_v[sel] = 1'b1;
    @(negedge clk);
    req_v[sel] = 1'b0;
    we_s = 1'($urandom); size_s = 2'($urandom); uns_s = 1'($urandom);
    addr_s = 12'($urandom); wdata_s = $urandom;
    n = 0; seen = 1'b0; got_rlow = 0;
    while (!seen && n < 40) begin
      if (!ready_v[sel]) got_rlow++;
      if (rvalid_v[sel]) begin
        seen = 1'b1;
        got_rdata = rdata_v[sel];
        got_mis = mis_v[sel];
        got_lat = n;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    checkOutput("rvalid_seen", 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput("ready_after", {30'd0, ready_v[sel], rvalid_v[sel]}, 32'd2);
  endtask

  task automatic doOp(input int sel, input logic w, input logic [1:0] sz,
                      input logic u, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] er;
    logic        em;
    modelAccess(sel, w, sz, u, a, wd, er, em);
    applyStimulus(sel, w, sz, u, a, wd);
    checkOutput("rdata", got_rdata, er);
    checkOutput("misaligned", 32'(got_mis), 32'(em));
    checkOutput("latency", 32'(got_lat), em ? 32'd0 : 32'(lat_of[sel]));
    checkOutput("ready_low", 32'(got_rlow), em ? 32'd1 : 32'(lat_of[sel] + 1));
  endtask

  initial begin
    logic [31:0] er;
    logic        em;
    logic        any_rvalid;
    total = 0; bad = 0;
    lat_of[0] = 2; lat_of[1] = 0; lat_of[2] = 3;
    for (int s = 0; s < 3; s++) begin
      rst_n_v[s] = 1'b0;
      req_v[s]   = 1'b0;
      for (int i = 0; i < 4096; i++) mb[s][i] = 8'd0;
    end
    we_s = 1'b0; size_s = 2'b00; uns_s = 1'b0; addr_s = 12'd0; wdata_s = 32'd0;

    // Reset values
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checkOutput("reset_flags", {29'd0, ready_v[s], rvalid_v[s], mis_v[s]}, 32'd4);
      checkOutput("reset_rdata", rdata_v[s], 32'd0);
      rst_n_v[s] = 1'b1;
    end

    // Fill a known region so every later load has defined contents
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 32; w++) doOp(s, 1'b1, 2'b10, 1'b0, 12'(w * 4), $urandom);
    end

    // Word, byte and misalignment directed sequence, LATENCY=2
    doOp(0, 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF);
    doOp(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    checkOutput("lw_deadbeef", got_rdata, 32'hDEADBEEF);
    checkOutput("lw_latency", 32'(got_lat), 32'd2);
    checkOutput("lw_ready_low", 32'(got_rlow), 32'd3);
    doOp(0, 1'b1, 2'b00, 1'b0, 12'h013, 32'h00000080);
    doOp(0, 1'b0, 2'b00, 1'b0, 12'h013, 32'h0);
    checkOutput("lb_sign", got_rdata, 32'hFFFFFF80);
    doOp(0, 1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
    checkOutput("lbu_zero", got_rdata, 32'h00000080);
    doOp(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    checkOutput("lw_after_sb", got_rdata, 32'h80ADBEEF);
    doOp(0, 1'b0, 2'b10, 1'b0, 12'h011, 32'h0);
    checkOutput("mis_lw", {31'd0, got_mis}, 32'd1);
    checkOutput("mis_lw_lat", 32'(got_lat), 32'd0);
    doOp(0, 1'b1, 2'b01, 1'b0, 12'h013, 32'h0000FFFF);
    checkOutput("mis_sh", {31'd0, got_mis}, 32'd1);
    doOp(0, 1'b1, 2'b11, 1'b0, 12'h010, 32'hFFFFFFFF);
    checkOutput("mis_size11", {31'd0, got_mis}, 32'd1);
    checkOutput("mis_size11_rdata", got_rdata, 32'd0);
    doOp(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    checkOutput("lw_unchanged", got_rdata, 32'h80ADBEEF);
    doOp(0, 1'b1, 2'b01, 1'b0, 12'h012, 32'h00008001);
    doOp(0, 1'b0, 2'b01, 1'b0, 12'h012, 32'h0);
    checkOutput("lh_sign", got_rdata, 32'hFFFF8001);
    doOp(0, 1'b0, 2'b01, 1'b1, 12'h012, 32'h0);
    checkOutput("lhu_zero", got_rdata, 32'h00008001);

    // Randomized accesses within the filled region
    for (int k = 0; k < 40; k++) begin
      doOp(0, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
           12'($urandom_range(0, 127)), $urandom);
    end
    for (int k = 0; k < 20; k++) begin
      doOp(1, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
           12'($urandom_range(0, 127)), $urandom);
    end

    // LATENCY=0 with req held high: accept every second cycle
    doOp(1, 1'b1, 2'b10, 1'b0, 12'h010, 32'h13579BDF);
    modelAccess(1, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, er, em);
    @(negedge clk);
    we_s = 1'b0; size_s = 2'b10; uns_s = 1'b0; addr_s = 12'h010; wdata_s = 32'h0;
    req_v[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("b2b_rvalid", 32'(rvalid_v[1]), 32'((i % 2) == 0));
      checkOutput("b2b_ready", 32'(ready_v[1]), 32'((i % 2) == 1));
      if (rvalid_v[1]) checkOutput("b2b_rdata", rdata_v[1], er);
    end
    req_v[1] = 1'b0;
    @(negedge clk);
    checkOutput("b2b_idle", {30'd0, ready_v[1], rvalid_v[1]}, 32'd2);
    checkOutput("b2b_model", er, 32'h13579BDF);

    // Reset during WAIT aborts the store, LATENCY=3
    doOp(2, 1'b1, 2'b10, 1'b0, 12'h020, 32'hCAFEF00D);
    @(negedge clk);
    we_s = 1'b1; size_s = 2'b10; uns_s = 1'b0; addr_s = 12'h020; wdata_s = 32'h12345678;
    req_v[2] = 1'b1;
    @(negedge clk);
    req_v[2] = 1'b0;
    checkOutput("wait_busy", 32'(ready_v[2]), 32'd0);
    @(negedge clk);
    rst_n_v[2] = 1'b0;
    #1;
    checkOutput("abort_flags", {29'd0, ready_v[2], rvalid_v[2], mis_v[2]}, 32'd4);
    checkOutput("abort_rdata", rdata_v[2], 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n_v[2] = 1'b1;
    any_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rvalid_v[2]) any_rvalid = 1'b1;
    end
    checkOutput("abort_no_rvalid", 32'(any_rvalid), 32'd0);
    doOp(2, 1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
    checkOutput("abort_prior", got_rdata, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
